rsa_key_wrap: RTL
=================

RSA_KEY_WRAP -- requirements
Module: rsa_key_wrap

Interface
REQ-001 Parameter TIMEOUT_CYC, 4096, cycles allowed per engine operation before abort.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 mode  input  1  0 = wrap (encrypt key), 1 = unwrap (decrypt key); sampled with start.
REQ-006 key_in  input  128  SM4 session key to wrap; sampled with start.
REQ-007 ct_in  input  130  wrapped key {ct_hi[64:0], ct_lo[64:0]}; sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  error flag, valid with done, held until next accepted start.
REQ-011 key_out  output  128  unwrapped key {hi[63:0], lo[63:0]}.
REQ-012 ct_out  output  130  wrapped key {ct_hi, ct_lo}.
REQ-013 rsa_cmd  output  2  engine command: 01 encrypt, 10 decrypt, 00 idle.
REQ-014 rsa_msg  output  65  engine operand.
REQ-015 rsa_p_msg  input  65  engine result.
REQ-016 rsa_p_sync  input  1  engine one-cycle result-valid pulse.

Function
REQ-017 States IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, FINISH; IDLE->ISSUE_LO on start.
REQ-018 Wrap operands: lo = {1'b0, key_in[63:0]}, hi = {1'b0, key_in[127:64]}; unwrap operands: ct_in[64:0], ct_in[129:65].
REQ-019 ISSUE_x drives rsa_cmd (01 wrap / 10 unwrap) and rsa_msg for exactly one cycle, then rsa_cmd returns to 00; ISSUE_x->WAIT_x unconditionally.
REQ-020 rsa_msg holds the current operand from ISSUE_x until leaving WAIT_x.
REQ-021 WAIT_LO captures rsa_p_msg on rsa_p_sync and goes to ISSUE_HI; WAIT_HI captures and goes to FINISH.
REQ-022 rsa_p_sync outside WAIT_LO/WAIT_HI is ignored.
REQ-023 Unwrap result with bit 64 set is invalid: err set, sequence continues to FINISH, key_out not updated.
REQ-024 FINISH pulses done for one cycle, updates ct_out (wrap) or key_out (unwrap) only when err=0, returns to IDLE.
REQ-025 start while busy is ignored; start coincident with done (FINISH cycle) is ignored.
REQ-026 Latency: done = start cycle + 4 + engine latency lo + engine latency hi.
REQ-027 key_out/ct_out hold their values between operations.

Reset
REQ-028 rst returns to IDLE from any state, including mid-WAIT, with busy=0, done=0, err=0, rsa_cmd=00, rsa_msg=0, key_out=0, ct_out=0.
REQ-029 The engine is reset by the same rst; rsa_p_sync in the cycle after rst deasserts is ignored.

Configuration
REQ-030 Macro RSA_WRAP_TIMEOUT_EN defined: a counter cleared in ISSUE_x counts in WAIT_x; reaching TIMEOUT_CYC sets err and jumps to FINISH.
REQ-031 Macro absent: no counter; WAIT_x waits indefinitely; TIMEOUT_CYC unused.

Structure
REQ-032 Shared package rsa_pkg holds the RSA_CMD_IDLE/ENC/DEC encodings, RSA_W=65, KEY_W=128, and the state typedef.
REQ-033 One sub-module rsa_wdog (timeout counter), instantiated only under RSA_WRAP_TIMEOUT_EN; the RSA engine is instantiated outside this block.

Verification
REQ-034 Wrap: key_in=128'h0000_0000_0000_0002_0000_0000_0000_0003 with engine model -> two single-cycle 01 commands, rsa_msg 3 then 2; ct_out={65'd131072, 65'd129140163}; err=0.
REQ-035 Unwrap: ct_in={65'd131072, 65'd129140163} -> two 10 commands; key_out=128'h...0002_...0003; done one cycle.
REQ-036 Unwrap: model returns rsa_p_msg[64]=1 on the hi operation -> done with err=1; key_out keeps its previous value.
REQ-037 Under RSA_WRAP_TIMEOUT_EN, model never pulses rsa_p_sync -> done with err=1 exactly TIMEOUT_CYC cycles after entering WAIT_LO.
REQ-038 start pulse during WAIT_LO, plus stray rsa_p_sync in IDLE -> no extra rsa_cmd issued; outputs unchanged.
REQ-039 rst asserted in WAIT_HI -> next cycle IDLE with all outputs 0; a fresh start completes normally.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared widths, engine command encodings and FSM state encoding for the RSA key-wrap slice.
package rsa_pkg;

    localparam int RSA_W  = 65;
    localparam int KEY_W  = 128;
    localparam int HALF_W = KEY_W / 2;

    localparam logic [1:0] RSA_CMD_IDLE = 2'b00;
    localparam logic [1:0] RSA_CMD_ENC  = 2'b01;
    localparam logic [1:0] RSA_CMD_DEC  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE_LO = 3'd1;
    localparam state_t ST_WAIT_LO  = 3'd2;
    localparam state_t ST_ISSUE_HI = 3'd3;
    localparam state_t ST_WAIT_HI  = 3'd4;
    localparam state_t ST_FINISH   = 3'd5;

    // A 64-bit key half becomes an engine operand with a clear top bit.
    function automatic logic [RSA_W-1:0] pad_half(input logic [HALF_W-1:0] half);
        return {1'b0, half};
    endfunction

endpackage

// File: rtl/rsa_wdog.sv
// Per-operation watchdog: cleared while a command is issued, counts waiting cycles,
// flags expiry on the LIMIT-th waiting cycle.
module rsa_wdog #(
    parameter int LIMIT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = count && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/rsa_key_wrap.sv
// RSA key wrap/unwrap sequencer: runs two 65-bit engine operations (lo half, then hi half).
// Optional per-operation abort watchdog enabled by defining RSA_WRAP_TIMEOUT_EN.
module rsa_key_wrap
    import rsa_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [2*RSA_W-1:0] ct_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [KEY_W-1:0]   key_out,
    output logic [2*RSA_W-1:0] ct_out,
    output logic [1:0]         rsa_cmd,
    output logic [RSA_W-1:0]   rsa_msg,
    input  logic [RSA_W-1:0]   rsa_p_msg,
    input  logic               rsa_p_sync
);

    state_t           state;
    logic             mode_q;
    logic [RSA_W-1:0] op_lo;
    logic [RSA_W-1:0] op_hi;
    logic [RSA_W-1:0] res_lo;
    logic [RSA_W-1:0] res_hi;
    logic             timeout;
    logic             accept;
    logic             bad_result;
    logic [1:0]       op_cmd;

    // The done cycle is spent in IDLE, so a start there must still be refused.
    assign accept     = (state == ST_IDLE) && start && !done;
    assign bad_result = mode_q && rsa_p_msg[RSA_W-1];
    assign op_cmd     = mode_q ? RSA_CMD_DEC : RSA_CMD_ENC;
    assign busy       = (state != ST_IDLE) || done;

`ifdef RSA_WRAP_TIMEOUT_EN
    logic in_issue;
    logic in_wait;

    assign in_issue = (state == ST_ISSUE_LO) || (state == ST_ISSUE_HI);
    assign in_wait  = (state == ST_WAIT_LO)  || (state == ST_WAIT_HI);

    // Abort decision is followed by FINISH and then done, so firing one waiting cycle
    // early puts done exactly TIMEOUT_CYC cycles after WAIT_x is entered.
    rsa_wdog #(
        .LIMIT(TIMEOUT_CYC - 1)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (in_issue),
        .count  (in_wait),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
            mode_q  <= 1'b0;
            op_lo   <= '0;
            op_hi   <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            key_out <= '0;
            ct_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q <= mode;
                        err    <= 1'b0;
                        op_lo  <= mode ? ct_in[RSA_W-1:0]
                                       : pad_half(key_in[HALF_W-1:0]);
                        op_hi  <= mode ? ct_in[2*RSA_W-1:RSA_W]
                                       : pad_half(key_in[KEY_W-1:HALF_W]);
                        state  <= ST_ISSUE_LO;
                    end
                end
                ST_ISSUE_LO: state <= ST_WAIT_LO;
                ST_WAIT_LO: begin
                    if (rsa_p_sync) begin
                        res_lo <= rsa_p_msg;
                        if (bad_result) err <= 1'b1;
                        state  <= ST_ISSUE_HI;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_FINISH;
                    end
                end
                ST_ISSUE_HI: state <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    if (rsa_p_sync) begin
                        res_hi <= rsa_p_msg;
                        if (bad_result) err <= 1'b1;
                        state  <= ST_FINISH;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done <= 1'b1;
                    if (!err) begin
                        if (mode_q) key_out <= {res_hi[HALF_W-1:0], res_lo[HALF_W-1:0]};
                        else        ct_out  <= {res_hi, res_lo};
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        rsa_cmd = RSA_CMD_IDLE;
        rsa_msg = '0;
        case (state)
            ST_ISSUE_LO: begin
                rsa_cmd = op_cmd;
                rsa_msg = op_lo;
            end
            ST_WAIT_LO: rsa_msg = op_lo;
            ST_ISSUE_HI: begin
                rsa_cmd = op_cmd;
                rsa_msg = op_hi;
            end
            ST_WAIT_HI: rsa_msg = op_hi;
            default: ;
        endcase
    end

endmodule
